// File: rtl/div_unit_if.sv
// Request/result bundle between the execute stage and the iterative divider.
// The master issues DIV/DIVU requests. The slave returns a stall request and HI/LO write data.
interface div_unit_if;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        stall_req;
  logic        result_valid;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  modport master (
    output start, signed_div, dividend, divisor, cancel,
    input  stall_req, result_valid, hi_we, lo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  start, signed_div, dividend, divisor, cancel,
    output stall_req, result_valid, hi_we, lo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider. It retires one quotient bit per cycle.
// It writes the remainder to HI and the quotient to LO.
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        sd;
  logic        sv;
  logic        dz;

  logic        accept;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] lo_res;
  logic [31:0] hi_res;

  assign accept = (state == IDLE) & bus.start & ~bus.cancel;
  assign neg_a  = bus.signed_div & bus.dividend[31];
  assign neg_b  = bus.signed_div & bus.divisor[31];
  assign mag_a  = neg_a ? -bus.dividend : bus.dividend;
  assign mag_b  = neg_b ? -bus.divisor  : bus.divisor;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    rem_sh  = {rem, quo[31]};
    diff    = rem_sh - {1'b0, dvsr};
    fits    = rem_sh >= {1'b0, dvsr};
    rem_nxt = fits ? diff[31:0] : rem_sh[31:0];
    quo_nxt = {quo[30:0], fits};
    // With a zero divisor, every step just shifts. rem then ends up equal to |dividend|,
    // and the sign fix-up below restores the original dividend for HI.
    lo_res  = dz ? 32'hFFFF_FFFF : ((sd ^ sv) ? -quo_nxt : quo_nxt);
    hi_res  = sd ? -rem_nxt : rem_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvsr         <= '0;
      sd           <= 1'b0;
      sv           <= 1'b0;
      dz           <= 1'b0;
      bus.hi_wdata <= '0;
      bus.lo_wdata <= '0;
    end else if (bus.cancel) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= CALC;
            cnt   <= '0;
            rem   <= '0;
            quo   <= mag_a;
            dvsr  <= mag_b;
            sd    <= neg_a;
            sv    <= neg_b;
            dz    <= (bus.divisor == 32'd0);
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state        <= DONE;
            bus.hi_wdata <= hi_res;
            bus.lo_wdata <= lo_res;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The stall request drops in the same cycle as a flush, so the pipeline is never held for a dead operation.
  assign bus.stall_req    = ~bus.cancel & (((state == IDLE) & bus.start) | (state == CALC));
  assign bus.result_valid = (state == DONE) & ~bus.cancel;
  assign bus.hi_we        = bus.result_valid;
  assign bus.lo_we        = bus.result_valid;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit. A stimulus process issues divisions and cycle-level timing checks.
// A monitor pops expected HI/LO values whenever the unit presents a result.
module tb_div_unit;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  div_unit_if dif ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: plain integer division with 64-bit signed arithmetic, plus the divide-by-zero rule.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(dif.stall_req), 32'd0);
    check({tag, "_valid_we"}, 32'({dif.result_valid, dif.hi_we, dif.lo_we}), 32'd0);
    check({tag, "_hi"}, dif.hi_wdata, 32'd0);
    check({tag, "_lo"}, dif.lo_wdata, 32'd0);
  endtask

  // Called about 1 time unit after a rising edge. start is driven in cycle 0.
  // The task returns about 1 time unit after the edge that opens the next free cycle.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int extra_k, input int cancel_k, input int rst_k);
    logic [31:0] elo;
    logic [31:0] ehi;
    int          c0;
    model(s, a, b, elo, ehi);
    dif.start      = 1'b1;
    dif.signed_div = s;
    dif.dividend   = a;
    dif.divisor    = b;
    dif.cancel     = 1'b0;
    c0 = cyc;
    if (cancel_k < 0 && rst_k < 0) sb_q.push_back('{elo, ehi, c0 + 33});
    @(negedge clk);
    check("stall_c0", 32'(dif.stall_req), 32'd1);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      dif.start  = (k == extra_k);
      dif.cancel = (k == cancel_k);
      if (k == extra_k) begin
        dif.signed_div = 1'b0;
        dif.dividend   = 32'd9;
        dif.divisor    = 32'd3;
      end else begin
        dif.signed_div = 1'($urandom);
        dif.dividend   = $urandom;
        dif.divisor    = $urandom;
      end
      if (k == rst_k) begin
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_busy");
        last_lo = '0;
        last_hi = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      check("stall", 32'(dif.stall_req), 32'(k <= 32 && k != cancel_k));
      check("valid_we", 32'({dif.result_valid, dif.hi_we, dif.lo_we}),
            (k == 33) ? 32'd7 : 32'd0);
      if (k == cancel_k) begin
        @(posedge clk);
        #1;
        dif.cancel = 1'b0;
        dif.start  = 1'b0;
        check("cancel_hi_hold", dif.hi_wdata, last_hi);
        check("cancel_lo_hold", dif.lo_wdata, last_lo);
        return;
      end
    end
    last_lo = elo;
    last_hi = ehi;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation, in lane and in cycle.
  always @(negedge clk) begin
    if (dif.result_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_result: got lo=%h hi=%h, wanted no result (cycle %0d)",
                 dif.lo_wdata, dif.hi_wdata, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("lo_quotient", dif.lo_wdata, e.lo);
        check("hi_remainder", dif.hi_wdata, e.hi);
        check("latency", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, wanted $finish before time limit");
    $fatal(1);
  end

  initial begin
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    rst            = 1'b1;
    dif.start      = 1'b0;
    dif.signed_div = 1'b0;
    dif.dividend   = '0;
    dif.divisor    = '0;
    dif.cancel     = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(1'b0, 32'd100,        32'd7,        -1, -1, -1);
    run_op(1'b1, 32'hFFFF_FFF9,  32'd2,        -1, -1, -1);
    run_op(1'b1, 32'd7,          32'hFFFF_FFFE, -1, -1, -1);
    run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, -1, -1, -1);
    run_op(1'b0, 32'd5,          32'd0,        -1, -1, -1);
    run_op(1'b1, 32'hFFFF_FFF0,  32'd0,        -1, -1, -1);
    run_op(1'b0, 32'd100,        32'd7,         5, -1, -1);
    run_op(1'b0, 32'd100,        32'd7,        -1, 10, -1);
    run_op(1'b0, 32'd9,          32'd3,        -1, -1, -1);
    run_op(1'b0, 32'd100,        32'd7,        -1, -1, 20);
    run_op(1'b0, 32'd1000,       32'd33,       -1, -1, -1);

    for (int i = 0; i < 24; i++) begin
      s   = 1'($urandom);
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = 32'd1;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = $urandom_range(1, 15);
        4: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: ;
      endcase
      run_op(s, a, b, -1, -1, -1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
